// File: rtl/quadrature_pkg.sv
// Shared quadrature encodings and the transition classifier used by every channel.
package quadrature_pkg;

    localparam logic [1:0] QD_DETENT = 2'b11;

    // Successor of each state, indexed by state: {succ(11), succ(10), succ(01), succ(00)}
    localparam logic [7:0] QD_CW_NEXT  = {2'b01, 2'b11, 2'b00, 2'b10};
    localparam logic [7:0] QD_CCW_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};

    localparam int unsigned QD_SUB_W = 4;

    typedef enum logic [1:0] {
        QD_NONE,
        QD_CW,
        QD_CCW,
        QD_ILLEGAL
    } qd_step_e;

    function automatic qd_step_e qd_step(input logic [1:0] prev, input logic [1:0] next);
        qd_step_e s;
        if (prev == next)
            s = QD_NONE;
        else if (next == QD_CW_NEXT[{prev, 1'b0} +: 2])
            s = QD_CW;
        else if (next == QD_CCW_NEXT[{prev, 1'b0} +: 2])
            s = QD_CCW;
        else
            s = QD_ILLEGAL;
        return s;
    endfunction

endpackage

// File: rtl/quadrature_channel.sv
// One encoder channel: synchroniser, glitch filter, direction decode,
// sub-step accumulation, position counter and sticky illegal-transition flag.
module quadrature_channel
    import quadrature_pkg::*;
#(
    parameter int COUNT_WIDTH      = 16,
    parameter int FILTER_DEPTH     = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter int WRAP             = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a,
    input  logic                   b,
    input  logic                   clear,
    output logic                   cw,
    output logic                   ccw,
    output logic [COUNT_WIDTH-1:0] position,
    output logic                   err
);

    localparam int unsigned FCNT_W = $clog2(FILTER_DEPTH + 1);
    localparam logic signed [QD_SUB_W-1:0] STEP_LIM = QD_SUB_W'(STEPS_PER_DETENT);
    localparam logic signed [QD_SUB_W-1:0] NEG_LIM  = -STEP_LIM;
    localparam logic signed [COUNT_WIDTH-1:0] POS_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic signed [COUNT_WIDTH-1:0] POS_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};

    logic [1:0]                    r_sync1, r_sync2, r_cand, r_filt, r_filt_d;
    logic [FCNT_W-1:0]             r_fcnt;
    logic [FCNT_W-1:0]             w_fcnt_inc;
    logic signed [QD_SUB_W-1:0]    r_sub, w_sub_sum, w_sub_next;
    logic signed [COUNT_WIDTH-1:0] r_pos, w_pos_next;
    logic                          r_cw, r_ccw, r_err;
    logic                          w_cw, w_ccw, w_err_set;
    qd_step_e                      w_step;

    assign w_fcnt_inc = r_fcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= QD_DETENT;
            r_sync2  <= QD_DETENT;
            r_cand   <= QD_DETENT;
            r_filt   <= QD_DETENT;
            r_filt_d <= QD_DETENT;
            r_fcnt   <= '0;
        end else begin
            r_sync1  <= {a, b};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            if (r_sync2 == r_filt) begin
                r_cand <= r_sync2;
                r_fcnt <= '0;
            end else if (r_sync2 != r_cand) begin
                // A new candidate counts as its own first sample
                r_cand <= r_sync2;
                r_fcnt <= FCNT_W'(1);
                if (FILTER_DEPTH == 1)
                    r_filt <= r_sync2;
            end else if (w_fcnt_inc >= FCNT_W'(FILTER_DEPTH)) begin
                r_filt <= r_sync2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= w_fcnt_inc;
            end
        end
    end

    always_comb begin
        w_step     = qd_step(r_filt_d, r_filt);
        w_cw       = 1'b0;
        w_ccw      = 1'b0;
        w_err_set  = 1'b0;
        w_sub_sum  = r_sub;
        w_sub_next = r_sub;
        case (w_step)
            QD_CW:   w_sub_sum = r_sub + QD_SUB_W'(1);
            QD_CCW:  w_sub_sum = r_sub - QD_SUB_W'(1);
            default: w_sub_sum = r_sub;
        endcase
        if (w_step == QD_ILLEGAL) begin
            w_err_set  = 1'b1;
            w_sub_next = '0;
        end else if (w_step != QD_NONE) begin
            if (w_sub_sum == STEP_LIM) begin
                w_cw       = 1'b1;
                w_sub_next = '0;
            end else if (w_sub_sum == NEG_LIM) begin
                w_ccw      = 1'b1;
                w_sub_next = '0;
            end else begin
                w_sub_next = w_sub_sum;
            end
            // Partial turns that return to the detent never carry over
            if (r_filt == QD_DETENT)
                w_sub_next = '0;
        end
    end

    always_comb begin
        w_pos_next = r_pos;
        if (w_cw && (WRAP != 0 || r_pos != POS_MAX))
            w_pos_next = r_pos + 1'b1;
        else if (w_ccw && (WRAP != 0 || r_pos != POS_MIN))
            w_pos_next = r_pos - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cw  <= 1'b0;
            r_ccw <= 1'b0;
            r_err <= 1'b0;
            r_sub <= '0;
            r_pos <= '0;
        end else begin
            r_cw  <= w_cw;
            r_ccw <= w_ccw;
            if (clear) begin
                r_err <= 1'b0;
                r_sub <= '0;
                r_pos <= '0;
            end else begin
                r_err <= r_err | w_err_set;
                r_sub <= w_sub_next;
                r_pos <= w_pos_next;
            end
        end
    end

    assign cw       = r_cw;
    assign ccw      = r_ccw;
    assign err      = r_err;
    assign position = r_pos;

endmodule

// File: rtl/quadrature_decoder.sv
// Multi-channel quadrature encoder front end; each channel is fully independent.
module quadrature_decoder
    import quadrature_pkg::*;
#(
    parameter int CHANNELS         = 1,
    parameter int COUNT_WIDTH      = 16,
    parameter int FILTER_DEPTH     = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter int WRAP             = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS-1:0]             a,
    input  logic [CHANNELS-1:0]             b,
    input  logic [CHANNELS-1:0]             clear,
    output logic [CHANNELS-1:0]             cw,
    output logic [CHANNELS-1:0]             ccw,
    output logic [CHANNELS*COUNT_WIDTH-1:0] position,
    output logic [CHANNELS-1:0]             err
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        quadrature_channel #(
            .COUNT_WIDTH      (COUNT_WIDTH),
            .FILTER_DEPTH     (FILTER_DEPTH),
            .STEPS_PER_DETENT (STEPS_PER_DETENT),
            .WRAP             (WRAP)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .a        (a[gi]),
            .b        (b[gi]),
            .clear    (clear[gi]),
            .cw       (cw[gi]),
            .ccw      (ccw[gi]),
            .position (position[gi*COUNT_WIDTH +: COUNT_WIDTH]),
            .err      (err[gi])
        );
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Drives several decoder configurations from shared encoder stimulus and checks
// them against a phase-index model of the encoder.
module tb_quadrature_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] ab0 = 2'b11;
    logic [1:0] ab1 = 2'b11;
    logic clear0 = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]  u0_cw, u0_ccw, u0_err;
    logic [31:0] u0_pos;
    logic [0:0]  u1_cw, u1_ccw, u1_err, u2_cw, u2_ccw, u2_err;
    logic [0:0]  u3_cw, u3_ccw, u3_err, u4_cw, u4_ccw, u4_err;
    logic [15:0] u1_pos, u2_pos;
    logic [3:0]  u3_pos, u4_pos;

    quadrature_decoder #(.CHANNELS(2), .COUNT_WIDTH(16), .FILTER_DEPTH(4), .STEPS_PER_DETENT(4), .WRAP(1)) u0 (
        .clk(clk), .rst(rst), .a({ab1[1], ab0[1]}), .b({ab1[0], ab0[0]}), .clear({1'b0, clear0}),
        .cw(u0_cw), .ccw(u0_ccw), .position(u0_pos), .err(u0_err));
    quadrature_decoder #(.CHANNELS(1), .COUNT_WIDTH(16), .FILTER_DEPTH(4), .STEPS_PER_DETENT(1), .WRAP(1)) u1 (
        .clk(clk), .rst(rst), .a(ab0[1]), .b(ab0[0]), .clear(clear0),
        .cw(u1_cw), .ccw(u1_ccw), .position(u1_pos), .err(u1_err));
    quadrature_decoder #(.CHANNELS(1), .COUNT_WIDTH(16), .FILTER_DEPTH(4), .STEPS_PER_DETENT(2), .WRAP(1)) u2 (
        .clk(clk), .rst(rst), .a(ab0[1]), .b(ab0[0]), .clear(clear0),
        .cw(u2_cw), .ccw(u2_ccw), .position(u2_pos), .err(u2_err));
    quadrature_decoder #(.CHANNELS(1), .COUNT_WIDTH(4), .FILTER_DEPTH(4), .STEPS_PER_DETENT(4), .WRAP(0)) u3 (
        .clk(clk), .rst(rst), .a(ab0[1]), .b(ab0[0]), .clear(clear0),
        .cw(u3_cw), .ccw(u3_ccw), .position(u3_pos), .err(u3_err));
    quadrature_decoder #(.CHANNELS(1), .COUNT_WIDTH(4), .FILTER_DEPTH(4), .STEPS_PER_DETENT(4), .WRAP(1)) u4 (
        .clk(clk), .rst(rst), .a(ab0[1]), .b(ab0[0]), .clear(clear0),
        .cw(u4_cw), .ccw(u4_ccw), .position(u4_pos), .err(u4_err));

    // Lanes 0..4: channel 0 of u0..u4 (stimulus group 0); lane 5: u0 channel 1 (group 1)
    int m_s[6]    = '{4, 1, 2, 4, 4, 4};
    int m_w[6]    = '{16, 16, 16, 4, 4, 16};
    int m_wrap[6] = '{1, 1, 1, 0, 1, 1};
    int m_grp[6]  = '{0, 0, 0, 0, 0, 1};
    int m_acc[6], m_pos[6], m_err[6], m_cw[6], m_ccw[6];
    int m_ph[2];
    int o_cw[6], o_ccw[6];
    int checks = 0;
    int failures = 0;

    logic [5:0] w_cw_all, w_ccw_all;
    assign w_cw_all  = {u0_cw[1], u4_cw[0], u3_cw[0], u2_cw[0], u1_cw[0], u0_cw[0]};
    assign w_ccw_all = {u0_ccw[1], u4_ccw[0], u3_ccw[0], u2_ccw[0], u1_ccw[0], u0_ccw[0]};

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) begin
                if (w_cw_all[i] === 1'b1) o_cw[i] = o_cw[i] + 1;
                if (w_ccw_all[i] === 1'b1) o_ccw[i] = o_ccw[i] + 1;
            end
        end
    end

    function automatic int obs_pos(input int lane);
        case (lane)
            0: return int'($signed(u0_pos[15:0]));
            1: return int'($signed(u1_pos));
            2: return int'($signed(u2_pos));
            3: return int'($signed(u3_pos));
            4: return int'($signed(u4_pos));
            default: return int'($signed(u0_pos[31:16]));
        endcase
    endfunction

    function automatic int obs_err(input int lane);
        case (lane)
            0: return int'(u0_err[0]);
            1: return int'(u1_err[0]);
            2: return int'(u2_err[0]);
            3: return int'(u3_err[0]);
            4: return int'(u4_err[0]);
            default: return int'(u0_err[1]);
        endcase
    endfunction

    function automatic logic [1:0] enc(input int p);
        case (p)
            0: return 2'b11;
            1: return 2'b01;
            2: return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_pos%0d", tag, i), obs_pos(i), m_pos[i]);
            chk($sformatf("%s_cw%0d", tag, i), o_cw[i], m_cw[i]);
            chk($sformatf("%s_ccw%0d", tag, i), o_ccw[i], m_ccw[i]);
            chk($sformatf("%s_err%0d", tag, i), obs_err(i), m_err[i]);
        end
    endtask

    function automatic int adv(input int lane, input int dir);
        int hi = (1 << (m_w[lane] - 1)) - 1;
        int lo = -(1 << (m_w[lane] - 1));
        int v = m_pos[lane] + dir;
        if (v > hi) v = (m_wrap[lane] != 0) ? lo : hi;
        if (v < lo) v = (m_wrap[lane] != 0) ? hi : lo;
        return v;
    endfunction

    // d = +1 cw quarter, -1 ccw quarter, 2 = jump across (illegal)
    task automatic model_move(input int g, input int d);
        int np = (m_ph[g] + d + 4) % 4;
        for (int i = 0; i < 6; i++) begin
            if (m_grp[i] == g) begin
                if (d == 2) begin
                    m_err[i] = 1;
                    m_acc[i] = 0;
                end else begin
                    m_acc[i] = m_acc[i] + d;
                    if (m_acc[i] == m_s[i]) begin
                        m_cw[i]++;
                        m_pos[i] = adv(i, 1);
                        m_acc[i] = 0;
                    end else if (m_acc[i] == -m_s[i]) begin
                        m_ccw[i]++;
                        m_pos[i] = adv(i, -1);
                        m_acc[i] = 0;
                    end
                    if (np == 0) m_acc[i] = 0;
                end
            end
        end
        m_ph[g] = np;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) begin
            m_pos[i] = 0;
            m_err[i] = 0;
            m_acc[i] = 0;
        end
    endtask

    task automatic drive(input int d0, input int d1);
        if (d0 != 0) model_move(0, d0);
        if (d1 != 0) model_move(1, d1);
        ab0 = enc(m_ph[0]);
        ab1 = enc(m_ph[1]);
    endtask

    task automatic step(input int d0, input int d1, input int hold);
        drive(d0, d1);
        repeat (hold) @(negedge clk);
    endtask

    task automatic detent(input int d0, input int d1);
        for (int q = 0; q < 4; q++) step(d0, d1, 8);
    endtask

    task automatic glitch(input int k);
        ab0[1] = ~ab0[1];
        repeat (k) @(negedge clk);
        ab0[1] = ~ab0[1];
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int r, d0, d1;
        for (int i = 0; i < 6; i++) begin
            m_acc[i] = 0; m_pos[i] = 0; m_err[i] = 0; m_cw[i] = 0; m_ccw[i] = 0;
            o_cw[i] = 0; o_ccw[i] = 0;
        end
        m_ph[0] = 0;
        m_ph[1] = 0;

        repeat (3) @(negedge clk);
        chk("rst_cw", int'(w_cw_all), 0);
        chk("rst_ccw", int'(w_ccw_all), 0);
        chk("rst_pos0", obs_pos(0), 0);
        chk("rst_err", int'({u0_err, u1_err, u2_err, u3_err, u4_err}), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_all("idle");

        detent(-1, 1);
        chk("ccw1_pulses", o_ccw[0], 1);
        chk("ccw1_pos", obs_pos(0), -1);
        detent(-1, 1);
        chk("ccw2_pos", obs_pos(0), -2);
        chk("ch1_opposite_pos", obs_pos(5), 2);
        chk_all("ccw");

        detent(1, -1);
        detent(1, -1);
        chk("cw_pulses", o_cw[0], 2);
        chk("cw_pos", obs_pos(0), 0);
        chk("cw_err", obs_err(0), 0);
        chk_all("cw");

        step(1, 0, 8);
        step(-1, 0, 8);
        for (int k = 1; k <= 3; k++) glitch(k);
        chk_all("jiggle_glitch");

        step(2, 2, 8);
        chk("illegal_err", obs_err(0), 1);
        chk_all("illegal");
        step(2, 2, 8);

        // Last quarter of a cw detent with clear landing on the pulse edge
        for (int q = 0; q < 3; q++) step(1, 0, 8);
        drive(1, 0);
        repeat (6) @(negedge clk);
        chk("lat_early", int'(u0_cw[0]), 0);
        clear0 = 1'b1;
        @(negedge clk);
        clear0 = 1'b0;
        model_clear();
        chk("lat_pulse", int'(u0_cw[0]), 1);
        chk("clear_pos", obs_pos(0), 0);
        chk("clear_err", obs_err(0), 0);
        @(negedge clk);
        chk("lat_one_cycle", int'(u0_cw[0]), 0);
        repeat (6) @(negedge clk);
        chk_all("clear");

        detent(1, -1);
        chk("res_s4", obs_pos(0), 1);
        chk("res_s1", obs_pos(1), 4);
        chk("res_s2", obs_pos(2), 2);
        for (int n = 0; n < 9; n++) detent(1, -1);
        chk("sat_hold", obs_pos(3), 7);
        chk("wrap_around", obs_pos(4), -6);
        chk("s1_40", obs_pos(1), 40);
        chk_all("sat");

        for (int n = 1; n <= 80; n++) begin
            r = $urandom_range(0, 19);
            d1 = $urandom_range(0, 2) - 1;
            if (r < 8) d0 = 1;
            else if (r < 16) d0 = -1;
            else if (r < 19) d0 = 0;
            else d0 = 2;
            if (d0 == 0) glitch($urandom_range(1, 3));
            else step(d0, (d0 == 2) ? 0 : d1, $urandom_range(4, 8));
            if (n % 10 == 0) begin
                repeat (8) @(negedge clk);
                chk_all($sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
